// File: rtl/player_bullet_if.sv
//------------------------------------------------------------------------------
// player_bullet_if: beam/frame inputs, ship and fire controls, collision pulse
// and the bullet position/render outputs of the player bullet block.
// master = the video/game side driving stimulus, slave = player_bullet.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface player_bullet_if;
  logic       v_sync;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       fire;
  logic [9:0] ship_x_pos;
  logic [3:0] scale;
  logic       hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       bullet_on;

  modport master (
    output v_sync, pix_x, pix_y, fire, ship_x_pos, scale, hit,
    input  bullet_x, bullet_y, bullet_active, bullet_on
  );

  modport slave (
    input  v_sync, pix_x, pix_y, fire, ship_x_pos, scale, hit,
    output bullet_x, bullet_y, bullet_active, bullet_on
  );
endinterface

// File: rtl/player_bullet.sv
//------------------------------------------------------------------------------
// player_bullet: single player bullet. A synchronized fire edge spawns the
// bullet above the ship on a frame tick; it climbs SPEED pixels per frame and
// retires when it leaves the top of the screen or when the mixer reports a hit.
// Optional refire lockout: define PLAYER_BULLET_COOLDOWN_EN to add a COOLDOWN
// state that blocks respawn for COOLDOWN_FRAMES frames after each bullet.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module player_bullet #(
  parameter int SPAWN_Y         = 432,
  parameter int SPEED           = 8,
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  player_bullet_if.slave bus
);

  localparam logic [10:0] X_LIMIT   = 11'(640 - BULLET_W);
  localparam logic [9:0]  SPAWN_ROW = 10'(SPAWN_Y);
  localparam logic [9:0]  STEP      = 10'(SPEED);
  localparam logic [10:0] W_EXT     = 11'(BULLET_W);
  localparam logic [10:0] H_EXT     = 11'(BULLET_H);

  // The lockout counter is 8 bits wide; reject configurations it cannot hold.
  if ((COOLDOWN_FRAMES < 1) || (COOLDOWN_FRAMES > 255)) begin : g_bad_cooldown
    $error("player_bullet: COOLDOWN_FRAMES must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
`ifdef PLAYER_BULLET_COOLDOWN_EN
    COOLDOWN = 2'd2,
`endif
    FLIGHT   = 2'd1
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  logic        fire_meta_r;
  logic        fire_sync_r;
  logic        fire_prev_r;
  logic [1:0]  sync_fill_r;
  logic        fire_armed_r;
  logic        fire_req_s;

  logic        vsync_prev_r;
  logic        frame_tick_s;

  logic        fire_pending_r;
  logic        set_pending_s;
  logic        spawn_s;
  logic        advance_s;
  logic        exit_s;

  logic [9:0]  bullet_x_r;
  logic [9:0]  bullet_y_r;
  logic        bullet_active_r;

  logic [10:0] spawn_sum_s;
  logic [9:0]  spawn_x_s;
  logic [10:0] px_s;
  logic [10:0] py_s;
  logic [10:0] bx_s;
  logic [10:0] by_s;
  logic        in_x_s;
  logic        in_y_s;

`ifdef PLAYER_BULLET_COOLDOWN_EN
  logic [7:0]  cd_cnt_r;
`endif

  // Fire synchronizer plus edge detector. sync_fill_r marks when fire_sync_r
  // holds a real sample; fire_armed_r only sets once fire has been seen low,
  // so a button held through reset release cannot look like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_meta_r  <= 1'b0;
      fire_sync_r  <= 1'b0;
      fire_prev_r  <= 1'b0;
      sync_fill_r  <= 2'b00;
      fire_armed_r <= 1'b0;
    end else begin
      fire_meta_r  <= bus.fire;
      fire_sync_r  <= fire_meta_r;
      fire_prev_r  <= fire_sync_r;
      sync_fill_r  <= {sync_fill_r[0], 1'b1};
      fire_armed_r <= fire_armed_r | (sync_fill_r[1] & ~fire_sync_r);
    end
  end

  assign fire_req_s = fire_sync_r & ~fire_prev_r & fire_armed_r;

  // Previous v_sync level for the frame tick rising-edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_r <= 1'b0;
    end else begin
      vsync_prev_r <= bus.v_sync;
    end
  end

  assign frame_tick_s = bus.v_sync & ~vsync_prev_r;

  // Spawn column: centre offset above the ship, clamped to the last column
  // where the whole bullet is still on screen.
  assign spawn_sum_s = {1'b0, bus.ship_x_pos} + ({7'd0, bus.scale} * 11'd6);
  assign spawn_x_s   = (spawn_sum_s > X_LIMIT) ? X_LIMIT[9:0] : spawn_sum_s[9:0];

  // Next-state and datapath control; a hit outranks a same-cycle frame tick.
  always_comb begin
    next_state_s  = state_r;
    spawn_s       = 1'b0;
    advance_s     = 1'b0;
    exit_s        = 1'b0;
    set_pending_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_tick_s && (fire_pending_r || fire_req_s)) begin
          spawn_s      = 1'b1;
          next_state_s = FLIGHT;
        end else begin
          set_pending_s = fire_req_s;
        end
      end
      FLIGHT: begin
        if (bus.hit) begin
          exit_s = 1'b1;
        end else if (frame_tick_s) begin
          if (bullet_y_r < STEP) begin
            exit_s = 1'b1;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          exit_s = 1'b0;
        end
        if (exit_s) begin
`ifdef PLAYER_BULLET_COOLDOWN_EN
          next_state_s = COOLDOWN;
`else
          next_state_s = IDLE;
`endif
        end else begin
          next_state_s = FLIGHT;
        end
      end
`ifdef PLAYER_BULLET_COOLDOWN_EN
      COOLDOWN: begin
        set_pending_s = fire_req_s;
        if (frame_tick_s && (cd_cnt_r <= 8'd1)) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = COOLDOWN;
        end
      end
`endif
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and registered active flag (tracks the FLIGHT state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      bullet_active_r <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      bullet_active_r <= (next_state_s == FLIGHT);
    end
  end

  // Bullet position: load on spawn, climb on frame ticks, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bullet_x_r <= 10'd0;
      bullet_y_r <= 10'd0;
    end else if (spawn_s) begin
      bullet_x_r <= spawn_x_s;
      bullet_y_r <= SPAWN_ROW;
    end else if (advance_s) begin
      bullet_y_r <= bullet_y_r - STEP;
    end else begin
      bullet_x_r <= bullet_x_r;
      bullet_y_r <= bullet_y_r;
    end
  end

  // Latched fire request waiting for the next frame tick; consumed by spawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_pending_r <= 1'b0;
    end else if (spawn_s) begin
      fire_pending_r <= 1'b0;
    end else if (set_pending_s) begin
      fire_pending_r <= 1'b1;
    end else begin
      fire_pending_r <= fire_pending_r;
    end
  end

`ifdef PLAYER_BULLET_COOLDOWN_EN
  // Refire lockout frame counter: loaded when the bullet retires, counted
  // down on each frame tick while cooling down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_cnt_r <= 8'd0;
    end else if (exit_s) begin
      cd_cnt_r <= 8'(COOLDOWN_FRAMES);
    end else if ((state_r == COOLDOWN) && frame_tick_s && (cd_cnt_r != 8'd0)) begin
      cd_cnt_r <= cd_cnt_r - 8'd1;
    end else begin
      cd_cnt_r <= cd_cnt_r;
    end
  end
`endif

  // Pixel hit test widened to 11 bits so bullet_x + BULLET_W cannot wrap.
  assign px_s   = {1'b0, bus.pix_x};
  assign py_s   = {1'b0, bus.pix_y};
  assign bx_s   = {1'b0, bullet_x_r};
  assign by_s   = {1'b0, bullet_y_r};
  assign in_x_s = (px_s >= bx_s) && (px_s < (bx_s + W_EXT));
  assign in_y_s = (py_s >= by_s) && (py_s < (by_s + H_EXT));

  assign bus.bullet_x      = bullet_x_r;
  assign bus.bullet_y      = bullet_y_r;
  assign bus.bullet_active = bullet_active_r;
  assign bus.bullet_on     = bullet_active_r & in_x_s & in_y_s;

endmodule

// File: tb/tb_player_bullet.sv
//------------------------------------------------------------------------------
// tb_player_bullet: scoreboard bench for player_bullet. Each stimulus step
// pushes the expected bullet state; the state is popped and compared once the
// DUT has had the frame to respond. Cooldown sequences follow
// PLAYER_BULLET_COOLDOWN_EN like the design.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_bullet;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  player_bullet_if bus ();

  player_bullet #(
    .SPAWN_Y        (432),
    .SPEED          (8),
    .BULLET_W       (2),
    .BULLET_H       (8),
    .COOLDOWN_FRAMES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic act, input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.tag = tag;
    e.act = act;
    e.x   = x;
    e.y   = y;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_active"}, 32'(bus.bullet_active), 32'(e.act));
      check({e.tag, "_x"},      32'(bus.bullet_x),      32'(e.x));
      check({e.tag, "_y"},      32'(bus.bullet_y),      32'(e.y));
    end
  endtask

  task automatic pix_check(input string tag, input int px, input int py, input logic exp);
    bus.pix_x = 10'(px);
    bus.pix_y = 10'(py);
    #1;
    check(tag, 32'(bus.bullet_on), 32'(exp));
  endtask

  // One video frame: v_sync high for 3 cycles, low for 4.
  task automatic frame();
    @(negedge clk);
    bus.v_sync = 1'b1;
    repeat (3) @(negedge clk);
    bus.v_sync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic fire_pulse();
    @(negedge clk);
    bus.fire = 1'b1;
    repeat (4) @(negedge clk);
    bus.fire = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_expect(input string tag, input logic act, input logic [9:0] x, input logic [9:0] y);
    push_exp(tag, act, x, y);
    frame();
    pop_check();
  endtask

  initial begin
    bus.v_sync     = 1'b0;
    bus.pix_x      = 10'd0;
    bus.pix_y      = 10'd0;
    bus.fire       = 1'b0;
    bus.ship_x_pos = 10'd0;
    bus.scale      = 4'd0;
    bus.hit        = 1'b0;
    rst_n          = 1'b0;

    repeat (3) @(negedge clk);
    push_exp("reset", 1'b0, 10'd0, 10'd0);
    pop_check();
    pix_check("reset_on", 0, 0, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    frame_expect("idle_nofire", 1'b0, 10'd0, 10'd0);

    // Spawn above the ship: 312 + 6*1 = 318.
    bus.ship_x_pos = 10'd312;
    bus.scale      = 4'd1;
    fire_pulse();
    frame_expect("spawn", 1'b1, 10'd318, 10'd432);
    pix_check("on_tl",    318, 432, 1'b1);
    pix_check("on_br",    319, 439, 1'b1);
    pix_check("on_right", 320, 432, 1'b0);
    pix_check("on_below", 319, 440, 1'b0);
    pix_check("on_above", 318, 431, 1'b0);

    // Climb to the top; a fire press mid-flight must not respawn.
    for (int k = 1; k <= 54; k++) begin
      if (k == 10) fire_pulse();
      frame_expect("flight", 1'b1, 10'd318, 10'(432 - 8 * k));
    end
    frame_expect("exit_top", 1'b0, 10'd318, 10'd0);

`ifdef PLAYER_BULLET_COOLDOWN_EN
    for (int f = 1; f <= 8; f++) begin
      if (f == 4) fire_pulse();
      frame_expect("cooldown", 1'b0, 10'd318, 10'd0);
    end
    frame_expect("refire_spawn", 1'b1, 10'd318, 10'd432);
`else
    frame_expect("no_refire", 1'b0, 10'd318, 10'd0);
    fire_pulse();
    frame_expect("respawn", 1'b1, 10'd318, 10'd432);
`endif

    for (int k = 1; k <= 29; k++) begin
      frame_expect("climb", 1'b1, 10'd318, 10'(432 - 8 * k));
    end

    // Hit and frame tick in the same cycle at y=200: hit wins, y holds.
    push_exp("hit_prio", 1'b0, 10'd318, 10'd200);
    @(negedge clk);
    bus.v_sync = 1'b1;
    bus.hit    = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    pop_check();
    repeat (2) @(negedge clk);
    bus.v_sync = 1'b0;
    repeat (4) @(negedge clk);
    frame_expect("after_hit", 1'b0, 10'd318, 10'd200);
`ifdef PLAYER_BULLET_COOLDOWN_EN
    for (int f = 2; f <= 8; f++) begin
      frame_expect("hit_cooldown", 1'b0, 10'd318, 10'd200);
    end
`endif

    // Clamp: 630 + 6*4 = 654 > 638.
    bus.ship_x_pos = 10'd630;
    bus.scale      = 4'd4;
    fire_pulse();
    frame_expect("clamp", 1'b1, 10'd638, 10'd432);
    pix_check("clamp_on_tl",  638, 432, 1'b1);
    pix_check("clamp_on_br",  639, 439, 1'b1);
    pix_check("clamp_on_lft", 637, 432, 1'b0);
    frame_expect("clamp_fly1", 1'b1, 10'd638, 10'd424);
    frame_expect("clamp_fly2", 1'b1, 10'd638, 10'd416);

    // Reset mid-flight with fire held through the release.
    push_exp("rst_mid", 1'b0, 10'd0, 10'd0);
    @(negedge clk);
    bus.fire = 1'b1;
    rst_n    = 1'b0;
    #1;
    pop_check();
    pix_check("rst_on", 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_expect("rst_held_fire", 1'b0, 10'd0, 10'd0);
    end
    bus.fire = 1'b0;
    repeat (6) @(negedge clk);
    fire_pulse();
    frame_expect("post_rst_spawn", 1'b1, 10'd638, 10'd432);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
